// File: rtl/obi_err_sbr_lat.sv
// OBI error subordinate: grants every request and answers each one in order, after a fixed minimum latency, with an error response.
// Define OBI_ERR_SBR_LOG_EN to log the first faulting request and count accepted requests.
module obi_err_sbr_lat #(
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          IdWidth     = 1,
  parameter int unsigned          NumMaxTrans = 2,
  parameter int unsigned          RspLatency  = 1,
  parameter bit                   UseRReady   = 1'b1,
  parameter logic [DataWidth-1:0] RspData     = 32'hBADCAB1E,
  parameter int unsigned          CntWidth    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [IdWidth-1:0]   aid_i,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic [IdWidth-1:0]   rid_o,
  output logic                 err_o,
  input  logic                 log_clr_i,
  output logic                 log_valid_o,
  output logic [AddrWidth-1:0] log_addr_o,
  output logic                 log_we_o,
  output logic [CntWidth-1:0]  log_cnt_o
);

  localparam int unsigned LatW = $clog2(RspLatency + 1);
  localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned OccW = $clog2(NumMaxTrans + 1);
  localparam logic [LatW-1:0] LatInit = LatW'(RspLatency - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(NumMaxTrans - 1);
  localparam logic [OccW-1:0] OccMax  = OccW'(NumMaxTrans);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [LatW-1:0] lat_dec_sat(input logic [LatW-1:0] v);
    return (v == '0) ? '0 : v - LatW'(1);
  endfunction

  logic [IdWidth-1:0] r_id  [NumMaxTrans];
  logic [LatW-1:0]    r_lat [NumMaxTrans];
  logic [PtrW-1:0]    r_wptr;
  logic [PtrW-1:0]    r_rptr;
  logic [OccW-1:0]    r_occ;

  logic w_push;
  logic w_pop;
  logic w_rvalid;

  // Grant depends only on registered occupancy, so a pop never feeds back into gnt_o.
  assign gnt_o    = (r_occ < OccMax);
  assign w_push   = req_i && gnt_o;
  assign w_rvalid = (r_occ != '0) && (r_lat[r_rptr] == '0);
  assign w_pop    = w_rvalid && (UseRReady ? rready_i : 1'b1);

  assign rvalid_o = w_rvalid;
  assign err_o    = w_rvalid;
  assign rdata_o  = w_rvalid ? RspData : '0;
  assign rid_o    = w_rvalid ? r_id[r_rptr] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OccW'(1);
        2'b01:   r_occ <= r_occ - OccW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Free slots also count down; harmless, since a push reloads the slot.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumMaxTrans; i++) begin
      if (rst_i) begin
        r_lat[i] <= '0;
      end else if (w_push && (r_wptr == PtrW'(i))) begin
        r_lat[i] <= LatInit;
      end else begin
        r_lat[i] <= lat_dec_sat(r_lat[i]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumMaxTrans; i++) begin
      if (w_push && (r_wptr == PtrW'(i))) r_id[i] <= aid_i;
    end
  end

`ifdef OBI_ERR_SBR_LOG_EN
  function automatic logic [CntWidth-1:0] cnt_inc_sat(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + CntWidth'(1);
  endfunction

  logic                 r_log_valid;
  logic [AddrWidth-1:0] r_log_addr;
  logic                 r_log_we;
  logic [CntWidth-1:0]  r_log_cnt;

  // A clear that coincides with an accept restarts the log with that request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_log_valid <= 1'b0;
      r_log_addr  <= '0;
      r_log_we    <= 1'b0;
      r_log_cnt   <= '0;
    end else if (log_clr_i) begin
      r_log_valid <= w_push;
      r_log_addr  <= w_push ? addr_i : '0;
      r_log_we    <= w_push && we_i;
      r_log_cnt   <= w_push ? CntWidth'(1) : '0;
    end else if (w_push) begin
      r_log_cnt <= cnt_inc_sat(r_log_cnt);
      if (!r_log_valid) begin
        r_log_valid <= 1'b1;
        r_log_addr  <= addr_i;
        r_log_we    <= we_i;
      end
    end
  end

  assign log_valid_o = r_log_valid;
  assign log_addr_o  = r_log_addr;
  assign log_we_o    = r_log_we;
  assign log_cnt_o   = r_log_cnt;
`else
  logic w_unused;
  assign w_unused    = ^{addr_i, we_i, log_clr_i};
  assign log_valid_o = 1'b0;
  assign log_addr_o  = '0;
  assign log_we_o    = 1'b0;
  assign log_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_obi_err_sbr_lat.sv
// Self-checking bench for obi_err_sbr_lat: three parameterisations share clock and reset.
module tb_obi_err_sbr_lat;

`ifdef OBI_ERR_SBR_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif
  localparam logic [31:0] RSP = 32'hBADCAB1E;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u_a: RspLatency=3, NumMaxTrans=2, UseRReady=1
  logic        a_req, a_gnt, a_we, a_aid, a_rvalid, a_rready, a_rid, a_err, a_clr, a_lv, a_lw;
  logic [31:0] a_addr, a_rdata, a_la;
  logic [15:0] a_lc;
  // u_b: NumMaxTrans=1, RspLatency=1, UseRReady=0, CntWidth=2
  logic        b_req, b_gnt, b_we, b_aid, b_rvalid, b_rready, b_rid, b_err, b_clr, b_lv, b_lw;
  logic [31:0] b_addr, b_rdata, b_la;
  logic [1:0]  b_lc;
  // u_c: NumMaxTrans=3, RspLatency=2, IdWidth=2
  logic        c_req, c_gnt, c_we, c_rvalid, c_rready, c_err, c_clr, c_lv, c_lw;
  logic [1:0]  c_aid, c_rid;
  logic [31:0] c_addr, c_rdata, c_la;
  logic [15:0] c_lc;

  obi_err_sbr_lat #(.NumMaxTrans(2), .RspLatency(3), .UseRReady(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr), .we_i(a_we),
    .aid_i(a_aid), .rvalid_o(a_rvalid), .rready_i(a_rready), .rdata_o(a_rdata), .rid_o(a_rid),
    .err_o(a_err), .log_clr_i(a_clr), .log_valid_o(a_lv), .log_addr_o(a_la), .log_we_o(a_lw),
    .log_cnt_o(a_lc));

  obi_err_sbr_lat #(.NumMaxTrans(1), .RspLatency(1), .UseRReady(1'b0), .CntWidth(2)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr), .we_i(b_we),
    .aid_i(b_aid), .rvalid_o(b_rvalid), .rready_i(b_rready), .rdata_o(b_rdata), .rid_o(b_rid),
    .err_o(b_err), .log_clr_i(b_clr), .log_valid_o(b_lv), .log_addr_o(b_la), .log_we_o(b_lw),
    .log_cnt_o(b_lc));

  obi_err_sbr_lat #(.NumMaxTrans(3), .RspLatency(2), .IdWidth(2)) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(c_req), .gnt_o(c_gnt), .addr_i(c_addr), .we_i(c_we),
    .aid_i(c_aid), .rvalid_o(c_rvalid), .rready_i(c_rready), .rdata_o(c_rdata), .rid_o(c_rid),
    .err_o(c_err), .log_clr_i(c_clr), .log_valid_o(c_lv), .log_addr_o(c_la), .log_we_o(c_lw),
    .log_cnt_o(c_lc));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic req; logic aid; logic rready;
    logic gnt; logic rvalid; logic rid;
  } vec_t;
  vec_t tbl[8];

  logic       sb_b[$];
  logic [1:0] sb_c[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Cycle-by-cycle vectors for u_a: latency 3, capacity 2, stalled then drained.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    {a_req, a_we, a_aid, a_rready, a_clr} = '0;  a_addr = '0;
    {b_req, b_we, b_aid, b_rready, b_clr} = '0;  b_addr = '0;
    {c_req, c_we, c_rready, c_clr} = '0; c_aid = '0; c_addr = '0;
    repeat (2) tick();

    @(negedge clk);
    chk("rst_a_gnt", a_gnt, 1);  chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_a_rid", a_rid, 0);  chk("rst_a_rdata", a_rdata, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_log", {a_lv, a_lw, a_la, a_lc}, 0);
    chk("rst_b_gnt", b_gnt, 1);  chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_c_gnt", c_gnt, 1);  chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_c_out", {c_rid, c_rdata, c_err}, 0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      a_req = tbl[i].req; a_aid = tbl[i].aid; a_rready = tbl[i].rready;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), a_gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_rvalid", i), a_rvalid, tbl[i].rvalid);
      chk($sformatf("tbl%0d_rid", i), a_rid, tbl[i].rid);
      chk($sformatf("tbl%0d_rdata", i), a_rdata, tbl[i].rvalid ? RSP : 32'h0);
      chk($sformatf("tbl%0d_err", i), a_err, tbl[i].rvalid);
      tick();
    end

    // Reset with two transactions in flight: nothing may come out afterwards.
    a_rready = 1'b1;
    a_req = 1'b1; a_aid = 1'b1; tick();
    a_aid = 1'b0; tick();
    a_req = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstfl_rvalid", a_rvalid, 0);
    chk("rstfl_gnt", a_gnt, 1);
    begin
      int stale = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (a_rvalid) stale++;
      end
      chk("rstfl_stale_rsp", stale, 0);
    end
    tick();
    a_rready = 1'b0;

    // u_b: rready ignored, capacity 1 -> one pulse every other cycle.
    begin
      int pulses = 0;
      int acc = 0;
      logic prev_v = 1'b0;
      b_req = 1'b1; b_addr = 32'h40; b_we = 1'b1; b_rready = 1'b0; b_aid = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk("b_gnt_vs_rvalid", b_gnt, !b_rvalid);
        if (b_rvalid) begin
          chk("b_single_pulse", prev_v, 0);
          pulses++;
          if (sb_b.size() == 0) chk("b_unexpected_rsp", 1, 0);
          else chk("b_rid", b_rid, sb_b.pop_front());
        end
        if (b_req && b_gnt) begin
          sb_b.push_back(b_aid);
          acc++;
        end
        prev_v = b_rvalid;
        tick();
        b_aid = acc[0];
      end
      b_req = 1'b0;
      chk("b_pulse_count", pulses, 10);
      chk("b_sb_empty", sb_b.size(), 0);
      @(negedge clk);
      chk("b_log_cnt_sat", b_lc, LOG ? 2'd3 : 2'd0);
      chk("b_log_addr", b_la, LOG ? 32'h40 : 32'h0);
      chk("b_log_we_valid", {b_lw, b_lv}, LOG ? 2'b11 : 2'b00);
      tick();
    end

    // u_c: IDs 0..3 through a depth-3 queue with random backpressure.
    begin
      int got = 0;
      logic [1:0] next_id = 2'd0;
      int sent = 0;
      logic stall = 1'b0;
      logic [1:0] prev_rid = 2'd0;
      for (int i = 0; i < 300 && got < 4; i++) begin
        c_req = (sent < 4); c_aid = next_id; c_rready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (stall) begin
          chk("c_hold_rvalid", c_rvalid, 1);
          chk("c_hold_rid", c_rid, prev_rid);
        end
        if (c_rvalid && c_rready) begin
          if (sb_c.size() == 0) chk("c_unexpected_rsp", 1, 0);
          else begin
            chk("c_rid_order", c_rid, sb_c.pop_front());
            chk("c_err", c_err, 1);
            chk("c_rdata", c_rdata, RSP);
            got++;
          end
        end
        if (c_req && c_gnt) begin
          sb_c.push_back(next_id);
          sent++;
          next_id = next_id + 2'd1;
        end
        stall = c_rvalid && !c_rready;
        prev_rid = c_rid;
        tick();
      end
      c_req = 1'b0; c_rready = 1'b0;
      chk("c_all_received", got, 4);
      chk("c_sb_empty", sb_c.size(), 0);
    end

    // Log on u_a: two accepts, then clear together with an accept, then clear alone.
    a_rready = 1'b1;
    a_req = 1'b1; a_addr = 32'h100; a_we = 1'b1;
    @(negedge clk);
    chk("log_gnt0", a_gnt, 1);
    tick();
    a_addr = 32'h200; a_we = 1'b0;
    @(negedge clk);
    chk("log_gnt1", a_gnt, 1);
    tick();
    a_req = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("log_valid", a_lv, LOG);
    chk("log_addr", a_la, LOG ? 32'h100 : 32'h0);
    chk("log_we", a_lw, LOG);
    chk("log_cnt", a_lc, LOG ? 16'd2 : 16'd0);
    chk("log_gnt_drained", a_gnt, 1);
    tick();
    a_req = 1'b1; a_clr = 1'b1; a_addr = 32'h300; a_we = 1'b0;
    tick();
    a_req = 1'b0; a_clr = 1'b0;
    @(negedge clk);
    chk("logclr_cnt", a_lc, LOG ? 16'd1 : 16'd0);
    chk("logclr_addr", a_la, LOG ? 32'h300 : 32'h0);
    chk("logclr_valid_we", {a_lv, a_lw}, LOG ? 2'b10 : 2'b00);
    tick();
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    @(negedge clk);
    chk("logclr_only", {a_lv, a_lw, a_la, a_lc}, 0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
